dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter and sequencer for the data port of the byte-lane data RAM (`ram_c`). It shares that port between the CPU load/store unit (master 0) and a secondary master such as a debug/loader engine (master 1). It registers the winning request and drives `d_en`/`re`/`we`/`mem_op`/`d_addr`/`d_data_in`, then waits for the RAM's `ram_ready` pulse. It returns read data, a one-cycle ack and an error flag to the granted master. The RAM's ready generator and this block run on the same clock.

## Interface
- `TIMEOUT`, default 8: number of WAIT cycles without `ram_ready` before the access is aborted; legal range 4..15.
- `clk`  in  1  system clock (same clock as the RAM's `clk`/`cpu_clk`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  access request, level, held until ack.
- `m0_we`, `m1_we`  in  1  1 = store, 0 = load.
- `m0_op`, `m1_op`  in  3  mem_op encoding: 0 byte, 1 half, 2 word, 4 signed byte, 5 signed half.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  store data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  valid with ack: illegal op or timeout.
- `m0_rdata`, `m1_rdata`  out  32  load result; valid with ack and held until that master's next ack.
- `d_en`, `re`, `we`  out  1  RAM port controls.
- `mem_op`  out  3  to RAM.
- `d_addr`, `d_data_in`  out  32  to RAM.
- `d_data_out`  in  32  RAM read data (combinational from RAM).
- `ram_ready`  in  1  RAM completion pulse.
- `grant`  out  2  one-hot owner of the in-flight access; 0 when idle.

## Operation
- States:
  - IDLE: no access in flight.
  - WAIT: access issued, waiting for `ram_ready`.
  - RESP: response cycle to the granted master.
- IDLE, arbitration:
  - Only one request high: grant it.
  - Both high: grant the master that was not granted last (`last_grant` register, reset to 1, so m0 wins the first tie).
- IDLE, on grant:
  - Latch `we`, `op`, `addr` and `wdata` of the winner into the command register.
  - Update `last_grant`.
  - Set `grant`.
- Legality check at grant. An op is illegal if:
  - `op` ∈ {3, 6, 7}, or
  - `we`=1 with `op[2]`=1.
- Illegal op: IDLE→RESP directly with err=1 and rdata=0. The RAM port is never driven.
- Legal op: IDLE→WAIT.
  - `d_en`=1, `we`=cmd_we, `re`=~cmd_we.
  - `mem_op`, `d_addr` and `d_data_in` are taken from the command register.
  - All six port outputs are registered and stable for the whole of WAIT.
- WAIT has a 4-bit cycle counter, cleared on entry.
  - `ram_ready`=1: capture `d_data_out` into the owner's rdata (loads only; stores leave rdata unchanged), err=0, go to RESP.
  - Counter reaches TIMEOUT−1 with `ram_ready`=0: err=1, rdata=0, go to RESP.
- RESP: lasts exactly one cycle.
  - Owner's ack=1 and err is valid.
  - All RAM port outputs are 0 and `grant`=0.
  - Next state is IDLE.
  - The low cycle lets the RAM's ready generator return to idle. It also keeps a requester that drops req on the cycle after ack from being re-granted.
- Request deasserted during WAIT: ignored. The access completes and ack is still pulsed.
- Non-owner master: its ack/err stay 0 and its rdata is untouched.
- Misalignment is not checked here; the RAM handles lane rotation.

## Timing
- Reset (async, any state):
  - State→IDLE, `last_grant`=1, counter=0.
  - All outputs 0: acks, errs, rdata, `d_en`, `re`, `we`, `mem_op`, `d_addr`, `d_data_in`, `grant`.
- Legal access, with req sampled high at edge E0 (cycle 0):
  - Port outputs high from cycle 1.
  - RAM ready seen in cycle 3.
  - Ack in cycle 4.
  - IDLE in cycle 5, with new arbitration at the end of cycle 5.
  - Throughput is 1 access per 5 cycles.
- Illegal op: ack+err in cycle 1; next arbitration in cycle 2.
- Timeout: ack+err in cycle TIMEOUT+1.
- `ram_ready` outside WAIT is ignored.
- `ram_ready` in the same cycle as the timeout condition counts as success.

## Test plan
- After reset, m0 word load at addr 0x10, RAM model returns 0xDEADBEEF with ready in cycle 3 → `re`=`d_en`=1 in cycles 1–3, `mem_op`=2, `d_addr`=0x10, `m0_ack`=1 in cycle 4, `m0_rdata`=0xDEADBEEF, `m0_err`=0.
- m0 and m1 both requesting continuously from reset → acks in the order m0, m1, m0, m1, 5 cycles apart; `grant` is one-hot during WAIT.
- m1 byte store at addr 0x3 with wdata 0x000000A5 → `we`=1, `re`=0, `mem_op`=0, `d_addr`=0x3, `d_data_in`=0xA5, `m1_ack` in cycle 4, `m1_rdata` unchanged.
- m0 store with op=4 → `m0_ack`=`m0_err`=1 in cycle 1, `d_en` never asserted, `m0_rdata`=0.
- `ram_ready` tied 0, m0 load, TIMEOUT=8 → `m0_ack`=`m0_err`=1 in cycle 9, rdata=0, port outputs 0 from cycle 9, next request serviced normally.
- `rst_n` pulled low in cycle 2 of an m1 access → all outputs 0 immediately; after release m0 wins a tie (`last_grant`=1); no ack is ever issued for the aborted access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and sequencer for the byte-lane data RAM port.
// Each access is one pass through IDLE -> WAIT (port driven) -> RESP (ack) -> IDLE.
module dmem_arbiter #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_op,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_op,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        d_en,
    output logic        re,
    output logic        we,
    output logic [2:0]  mem_op,
    output logic [31:0] d_addr,
    output logic [31:0] d_data_in,
    input  logic [31:0] d_data_out,
    input  logic        ram_ready,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t           state_q;
    logic             last_grant_q;  // index of the master granted most recently
    logic [3:0]       cnt_q;
    logic [1:0]       ack_q;
    logic [1:0]       err_q;
    logic [1:0][31:0] rdata_q;
    logic             d_en_q;
    logic             re_q;
    logic             we_q;
    logic [2:0]       mem_op_q;
    logic [31:0]      d_addr_q;
    logic [31:0]      d_data_in_q;
    logic [1:0]       grant_q;

    // Arbitration and the winner's command, evaluated while IDLE.
    logic        any_req;
    logic        pick_m1;
    logic        sel_we;
    logic [2:0]  sel_op;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_illegal;
    logic        owner;
    logic        wait_done;

    assign any_req     = m0_req | m1_req;
    assign pick_m1     = m1_req & (~m0_req | ~last_grant_q);
    assign sel_we      = pick_m1 ? m1_we    : m0_we;
    assign sel_op      = pick_m1 ? m1_op    : m0_op;
    assign sel_addr    = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wdata   = pick_m1 ? m1_wdata : m0_wdata;
    assign sel_illegal = (sel_op == 3'd3) || (sel_op == 3'd6) || (sel_op == 3'd7) ||
                         (sel_we && sel_op[2]);
    assign owner       = grant_q[1];
    assign wait_done   = ram_ready || (cnt_q == CNT_LAST);

    // NOTE: all state below is written with <= so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            d_en_q       <= 1'b0;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            mem_op_q     <= '0;
            d_addr_q     <= '0;
            d_data_in_q  <= '0;
            grant_q      <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        last_grant_q <= pick_m1;
                        if (sel_illegal) begin
                            state_q          <= ST_RESP;
                            ack_q[pick_m1]   <= 1'b1;
                            err_q[pick_m1]   <= 1'b1;
                            rdata_q[pick_m1] <= '0;
                        end else begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= '0;
                            d_en_q      <= 1'b1;
                            re_q        <= ~sel_we;
                            we_q        <= sel_we;
                            mem_op_q    <= sel_op;
                            d_addr_q    <= sel_addr;
                            d_data_in_q <= sel_wdata;
                            grant_q     <= pick_m1 ? 2'b10 : 2'b01;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        // ready on the final counted cycle still counts as success
                        state_q        <= ST_RESP;
                        ack_q[owner]   <= 1'b1;
                        err_q[owner]   <= ~ram_ready;
                        if (!ram_ready) begin
                            rdata_q[owner] <= '0;
                        end else if (!we_q) begin
                            rdata_q[owner] <= d_data_out;
                        end
                        cnt_q       <= '0;
                        d_en_q      <= 1'b0;
                        re_q        <= 1'b0;
                        we_q        <= 1'b0;
                        mem_op_q    <= '0;
                        d_addr_q    <= '0;
                        d_data_in_q <= '0;
                        grant_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign d_en      = d_en_q;
    assign re        = re_q;
    assign we        = we_q;
    assign mem_op    = mem_op_q;
    assign d_addr    = d_addr_q;
    assign d_data_in = d_data_in_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a RAM model with programmable ready latency
// and a scoreboard of expected acks, popped whenever the DUT acknowledges.
module tb_dmem_arbiter;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [2:0]  m0_op = '0, m1_op = '0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        d_en, re, we;
    logic [2:0]  mem_op;
    logic [31:0] d_addr, d_data_in, d_data_out;
    logic        ram_ready = 1'b0;
    logic [1:0]  grant;

    logic [31:0] ram_xor = '0;
    int          ready_at = 3;
    int          en_cycles = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          m;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rd [2];

    dmem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .d_en(d_en), .re(re), .we(we), .mem_op(mem_op), .d_addr(d_addr),
        .d_data_in(d_data_in), .d_data_out(d_data_out), .ram_ready(ram_ready),
        .grant(grant)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data derived from the address, ready on the Nth enabled cycle.
    assign d_data_out = ram_xor ^ d_addr;
    always @(negedge clk) begin
        if (d_en) begin
            en_cycles = en_cycles + 1;
            ram_ready = (en_cycles == ready_at);
        end else begin
            en_cycles = 0;
            ram_ready = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (m0_ack || m1_ack) begin
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_ack: observed ack=%b%b at cycle %0d expected none",
                       m1_ack, m0_ack, cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ack_owner", 64'({m1_ack, m0_ack}), e.m ? 64'd2 : 64'd1);
                check("ack_err", 64'({m1_err, m0_err}), e.err ? (e.m ? 64'd2 : 64'd1) : 64'd0);
                check("ack_rdata", 64'(e.m ? m1_rdata : m0_rdata), 64'(e.rdata));
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drive(input bit m, input logic req, input logic w, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_req = req; m1_we = w; m1_op = op; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = w; m0_op = op; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // One access from a single master, with its outcome predicted from the op
    // legality rules and the RAM model's ready latency.
    task automatic access(input bit m, input logic w, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit          illegal;
        bit          tmo;
        bit          err;
        int          lat;
        logic [31:0] rd;
        illegal = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (w && op[2]);
        tmo     = !illegal && (ready_at < 1 || ready_at > int'(TMO));
        err     = illegal || tmo;
        lat     = illegal ? 1 : (tmo ? int'(TMO) + 1 : ready_at + 1);
        rd      = err ? 32'h0 : (w ? exp_rd[m] : (ram_xor ^ addr));
        drive(m, 1'b1, w, op, addr, wdata);
        sb.push_back('{m, err, rd, cyc + lat});
        tick();
        if (illegal) begin
            check("c1_port_idle", 64'({d_en, re, we, grant}), 64'd0);
        end else begin
            check("c1_ctrl", 64'({d_en, re, we, mem_op, grant}),
                  64'({1'b1, ~w, w, op, (m ? 2'b10 : 2'b01)}));
            check("c1_addr", 64'(d_addr), 64'(addr));
            check("c1_wdata", 64'(d_data_in), 64'(wdata));
        end
        for (int c = 2; c <= lat; c++) begin
            tick();
            if (c == lat - 1) check("wait_hold", 64'({d_en, d_addr}), 64'({1'b1, addr}));
        end
        check("resp_port", 64'({d_en, re, we, mem_op, grant}), 64'd0);
        check("resp_bus", {d_addr, d_data_in}, 64'd0);
        drive(m, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        exp_rd[m] = rd;
        check("other_rdata", 64'(m ? m0_rdata : m1_rdata), 64'(exp_rd[m ? 0 : 1]));
        tick();
    endtask

    initial begin
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        tick();
        tick();
        check("rst_ctrl", 64'({d_en, re, we, mem_op, grant, m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
        check("rst_bus", {d_addr, d_data_in}, 64'd0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Both masters requesting continuously: alternate, 5 cycles apart, m0 first.
        ram_xor = 32'h1111_0000;
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h200, 32'h0);
        sb.push_back('{1'b0, 1'b0, 32'h1111_0100, cyc + 4});
        sb.push_back('{1'b1, 1'b0, 32'h1111_0200, cyc + 9});
        sb.push_back('{1'b0, 1'b0, 32'h1111_0100, cyc + 14});
        sb.push_back('{1'b1, 1'b0, 32'h1111_0200, cyc + 19});
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c % 5 == 1) check("tie_grant", 64'(grant), (c % 10 == 1) ? 64'd1 : 64'd2);
            if (c % 5 == 4) check("tie_resp_grant", 64'(grant), 64'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        exp_rd[0] = 32'h1111_0100;
        exp_rd[1] = 32'h1111_0200;
        tick();

        // m0 word load returning 0xDEADBEEF.
        ram_xor = 32'hDEAD_BEEF ^ 32'h10;
        access(1'b0, 1'b0, 3'd2, 32'h10, 32'h0);

        // m1 byte store: rdata must not pick up the RAM's read bus.
        ram_xor = 32'hBAD0_0000;
        access(1'b1, 1'b1, 3'd0, 32'h3, 32'hA5);

        // Illegal ops: signed store and reserved op 7.
        access(1'b0, 1'b1, 3'd4, 32'h20, 32'h55);
        access(1'b1, 1'b0, 3'd7, 32'h24, 32'h0);

        // Timeout, then normal service, then ready on the final counted cycle.
        ram_xor  = 32'h0F0F_0000;
        ready_at = 0;
        access(1'b0, 1'b0, 3'd2, 32'h40, 32'h0);
        ready_at = 3;
        access(1'b0, 1'b0, 3'd1, 32'h42, 32'h0);
        ready_at = int'(TMO);
        access(1'b1, 1'b0, 3'd5, 32'h46, 32'h0);
        ready_at = 3;

        // Reset in cycle 2 of an m1 access: no ack ever, m0 wins the following tie.
        ram_xor = 32'h5A5A_0000;
        drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h80, 32'h0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", 64'({d_en, re, we, mem_op, grant, m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
        check("arst_bus", {d_addr, d_data_in}, 64'd0);
        check("arst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h90, 32'h0);
        sb.push_back('{1'b0, 1'b0, 32'h5A5A_0090, cyc + 4});
        sb.push_back('{1'b1, 1'b0, 32'h5A5A_0080, cyc + 9});
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) check("post_rst_grant", 64'(grant), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
